// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - frame constants, FSM states and Q8.8-to-DAC code conversion for the SPI DAC transmitter
package dac_spi_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CODE_W  = 12;

  typedef enum logic [1:0] {
    PD_NORMAL   = 2'b00,
    PD_1K_GND   = 2'b01,
    PD_100K_GND = 2'b10,
    PD_HIGH_Z   = 2'b11
  } pd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // Signed Q8.8 to offset binary: keep the top 12 bits, flip the sign bit.
  function automatic logic [CODE_W-1:0] q88_to_dac_code(input logic [15:0] q88);
    return q88[15:4] ^ 12'h800;
  endfunction

  function automatic logic [FRAME_W-1:0] dac_frame(input logic [15:0] q88);
    return {2'b00, PD_NORMAL, q88_to_dac_code(q88)};
  endfunction

endpackage

// File: rtl/dac_spi_clkgen.sv
// rtl/dac_spi_clkgen.sv - sclk half-period divider producing rise/fall strobes for the SPI DAC transmitter
module dac_spi_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             high_q, high_d;
  logic             tick;

  // high_q mirrors the sclk level so each tick is known to be a fall or a rise.
  always_comb begin
    tick   = en && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    high_d = high_q;
    if (clr) begin
      cnt_d  = '0;
      high_d = 1'b1;
    end else if (en) begin
      if (tick) begin
        cnt_d  = '0;
        high_d = ~high_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      high_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

  assign fall_tick = tick & high_q;
  assign rise_tick = tick & ~high_q;

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - SPI master sending Q8.8 control words to a 12-bit DAC with a 1-deep pending word
// Optional idle auto-refresh of the last frame: define DAC_TX_REFRESH_EN.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned REFRESH_CYCLES = 1000
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        sync_n,
  output logic        sclk,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // Out-of-range parameter sets elaborate this named marker scope.
  if (CLK_DIV < 2 || GAP_CYCLES < 1 || REFRESH_CYCLES < 1) begin : g_illegal_params
  end

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [FRAME_W-1:0]   pend_frame_q, pend_frame_d;
  logic                 sync_n_q, sync_n_d;
  logic                 sclk_q, sclk_d;
  logic                 dout_q, dout_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic                 rise_tick, fall_tick;
  logic                 shifting;
  logic                 refresh_due;
  logic [FRAME_W-1:0]   refresh_frame;

  assign shifting = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

  dac_spi_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (Clk),
    .rst       (Rest),
    .clr       (~shifting),
    .en        (shifting),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

`ifdef DAC_TX_REFRESH_EN
  localparam int unsigned IDLE_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES - 1);

  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [FRAME_W-1:0] last_frame_q, last_frame_d;

  always_comb begin
    idle_cnt_d   = '0;
    last_frame_d = last_frame_q;
    if (state_q == ST_IDLE) begin
      idle_cnt_d = (idle_cnt_q == IDLE_LAST) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
    if (state_d == ST_LOAD) begin
      last_frame_d = pend_frame_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      idle_cnt_q   <= '0;
      last_frame_q <= 16'h0800;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      last_frame_q <= last_frame_d;
    end
  end

  assign refresh_due   = (state_q == ST_IDLE) && (idle_cnt_q == IDLE_LAST) && !pend_valid_q;
  assign refresh_frame = last_frame_q;
`else
  assign refresh_due   = 1'b0;
  assign refresh_frame = '0;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The 16th rising edge closes the frame; earlier rises present the next bit.
        if (rise_tick) begin
          if (bit_cnt_q == 4'd15) begin
            state_d = ST_GAP;
          end else begin
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) state_d = pend_valid_q ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD) begin
      shreg_d   = pend_frame_q;
      bit_cnt_d = 4'd0;
    end
  end

  // Pending is consumed on the edge into LOAD, so a word arriving on that same
  // edge or during LOAD lands in an empty slot.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_frame_d = pend_frame_q;
    overrun_d    = 1'b0;
    if (state_d == ST_LOAD) pend_valid_d = 1'b0;
    if (data_valid) begin
      pend_valid_d = 1'b1;
      pend_frame_d = dac_frame(data_in);
      overrun_d    = pend_valid_q && (state_d != ST_LOAD);
    end else if (refresh_due) begin
      pend_valid_d = 1'b1;
      pend_frame_d = refresh_frame;
    end
  end

  always_comb begin
    sync_n_d = !((state_d == ST_LOAD) || (state_d == ST_SHIFT));
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_SHIFT) && (state_d == ST_GAP);
    sclk_d   = 1'b1;
    dout_d   = 1'b0;
    if (state_d == ST_LOAD) begin
      dout_d = pend_frame_q[FRAME_W-1];
    end else if (state_d == ST_SHIFT) begin
      dout_d = shreg_d[FRAME_W-1];
      if (fall_tick)      sclk_d = 1'b0;
      else if (rise_tick) sclk_d = 1'b1;
      else                sclk_d = sclk_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_frame_q <= '0;
      sync_n_q     <= 1'b1;
      sclk_q       <= 1'b1;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_frame_q <= pend_frame_d;
      sync_n_q     <= sync_n_d;
      sclk_q       <= sclk_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sync_n  = sync_n_q;
  assign sclk    = sclk_q;
  assign dout    = dout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - directed scoreboard bench for dac_spi_tx (CLK_DIV=4, GAP_CYCLES=8)
module tb_dac_spi_tx;

  logic        Clk = 1'b0;
  logic        Rest = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        sync_n, sclk, dout, busy, done, overrun;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int done_cnt = 0;
  int overrun_cnt = 0;
  int frames_seen = 0;
  bit abort_frame = 1'b0;
  logic [15:0] exp_q[$];

  logic        m_prev_sync = 1'b1;
  logic        m_prev_sclk = 1'b1;
  logic [15:0] m_shift = '0;
  int          m_falls = 0;
  int          m_low = 0;

  dac_spi_tx #(
    .CLK_DIV        (4),
    .GAP_CYCLES     (8),
    .REFRESH_CYCLES (1000)
  ) dut (
    .Clk        (Clk),
    .Rest       (Rest),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sync_n     (sync_n),
    .sclk       (sclk),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Deserialise on sclk falls while sync_n is low; score each frame when sync_n rises.
  always @(negedge Clk) begin
    if (done === 1'b1) done_cnt++;
    if (overrun === 1'b1) overrun_cnt++;
    if (m_prev_sync === 1'b1 && sync_n === 1'b0) begin
      m_falls = 0;
      m_low = 0;
      m_shift = '0;
    end
    if (sync_n === 1'b0) begin
      m_low++;
      if (m_prev_sclk === 1'b1 && sclk === 1'b0) begin
        m_shift = {m_shift[14:0], dout};
        m_falls++;
      end
    end
    if (m_prev_sync === 1'b0 && sync_n === 1'b1) begin
      if (abort_frame) begin
        abort_frame = 1'b0;
      end else begin
        frames_seen++;
        check("frame_falls", m_falls, 16);
        check("frame_sync_low_cycles", m_low, 128);
        if (exp_q.size() == 0) check("unexpected_frame", {16'h0, m_shift}, 32'hFFFF_FFFF);
        else check("frame_data", {16'h0, m_shift}, {16'h0, exp_q.pop_front()});
      end
    end
    m_prev_sync = sync_n;
    m_prev_sclk = sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send(input logic [15:0] w, input logic [15:0] f);
    data_in = w;
    data_valid = 1'b1;
    exp_q.push_back(f);
    @(negedge Clk);
    data_valid = 1'b0;
  endtask

  task automatic pulse_only(input logic [15:0] w);
    data_in = w;
    data_valid = 1'b1;
    @(negedge Clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge Clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    int f, k, hi, ov, dc, fs;
    logic ps;

    // Reset state
    tick(4);
    check("rst_sync_n", sync_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_dout", dout, 0);
    check("rst_busy_done_overrun", {busy, done, overrun}, 0);
    Rest = 1'b0;
    tick(2);

    // 1: single frame, latency, done and busy timing
    send(16'h4B00, 16'h0CB0);
    check("t1_sync_n_after_1", sync_n, 1);
    tick(1);
    check("t1_sync_n_after_2", sync_n, 0);
    check("t1_busy_at_load", busy, 1);
    check("t1_sclk_at_load", sclk, 1);
    wait_done(400, "t1_done");
    tick(1);
    check("t1_done_one_cycle", done, 0);
    tick(6);
    check("t1_busy_gap_end", busy, 1);
    tick(1);
    check("t1_busy_low_after_gap", busy, 0);
    check("t1_done_count", done_cnt, 1);

    // 2: code extremes and midscale
    send(16'h8000, 16'h0000);
    wait_done(400, "t2_done_a");
    send(16'h7FFF, 16'h0FFF);
    wait_done(400, "t2_done_b");
    send(16'h0000, 16'h0800);
    wait_done(400, "t2_done_c");
    wait_idle("t2_idle");

    // 3: pending overwritten mid-frame, newest wins
    ov = overrun_cnt;
    send(16'h4B00, 16'h0CB0);
    tick(20);
    pulse_only(16'h1000);
    tick(3);
    send(16'h2000, 16'h0A00);
    tick(2);
    check("t3_overrun_once", overrun_cnt - ov, 1);
    wait_done(400, "t3_done_a");
    wait_done(400, "t3_done_b");
    wait_idle("t3_idle");
    check("t3_overrun_still_once", overrun_cnt - ov, 1);

    // 4: reset at the 8th falling edge, with a word pending
    dc = done_cnt;
    fs = frames_seen;
    send(16'h4B00, 16'h0CB0);
    f = 0;
    k = 0;
    ps = sclk;
    while (f < 8 && k < 400) begin
      @(negedge Clk);
      k++;
      if (k == 4) begin
        data_in = 16'h1000;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      if (sync_n === 1'b0 && ps === 1'b1 && sclk === 1'b0) f++;
      ps = sclk;
    end
    check("t4_reached_8_falls", f, 8);
    abort_frame = 1'b1;
    Rest = 1'b1;
    @(negedge Clk);
    check("t4_sync_n", sync_n, 1);
    check("t4_sclk", sclk, 1);
    check("t4_dout", dout, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    exp_q.delete();
    tick(2);
    Rest = 1'b0;
    tick(300);
    check("t4_no_frame_after_reset", frames_seen, fs);
    check("t4_no_done", done_cnt, dc);
    send(16'h4B00, 16'h0CB0);
    wait_done(400, "t4_done_clean");
    wait_idle("t4_idle");

    // 5: data_valid coincident with done
    send(16'h4B00, 16'h0CB0);
    wait_done(400, "t5_done_a");
    ov = overrun_cnt;
    data_in = 16'h4B00;
    data_valid = 1'b1;
    exp_q.push_back(16'h0CB0);
    hi = 0;
    while (sync_n === 1'b1 && hi < 40) begin
      hi++;
      @(negedge Clk);
      data_valid = 1'b0;
    end
    check("t5_gap_high_cycles", hi, 8);
    wait_done(400, "t5_done_b");
    tick(2);
    check("t5_no_overrun", overrun_cnt, ov);
    wait_idle("t5_idle");

    // 6: idle behaviour
`ifdef DAC_TX_REFRESH_EN
    exp_q.push_back(16'h0CB0);
    wait_done(1500, "t6_refresh_a");
    exp_q.push_back(16'h0CB0);
    wait_done(1500, "t6_refresh_b");
    wait_idle("t6_idle");
`else
    fs = frames_seen;
    dc = done_cnt;
    tick(5000);
    check("t6_no_frames", frames_seen, fs);
    check("t6_no_done", done_cnt, dc);
    check("t6_sync_n_idle", sync_n, 1);
`endif

    tick(4);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
